// File: rtl/psum_group_sequencer_pkg.sv
// Shared types and default widths for the psum group sequencer.
package psum_seq_pkg;
    localparam int F_WIDTH = 6;
    localparam int n_WIDTH = 3;
    localparam int e_WIDTH = 8;
    localparam int p_WIDTH = 5;
    localparam int t_WIDTH = 3;
    localparam int G_WIDTH = 4;
    localparam int A_WIDTH = 16;
    localparam int C_WIDTH = p_WIDTH + t_WIDTH;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} seq_state_e;

    typedef struct packed {
        logic [n_WIDTH-1:0] n;
        logic [F_WIDTH-1:0] f;
        logic [p_WIDTH-1:0] p;
        logic [e_WIDTH-1:0] e;
        logic [t_WIDTH-1:0] t;
    } beat_t;
endpackage

// File: rtl/psum_group_sequencer_if.sv
// Beat stream bus of the psum group sequencer (valid/ready plus indices).
// linear_addr is present only when PSUM_SEQ_LINEAR_EN is defined.
interface psum_group_sequencer_if;
    import psum_seq_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [n_WIDTH-1:0] psum_index;
    logic [C_WIDTH-1:0] channel_index;
    logic [e_WIDTH-1:0] row_index;
    logic [F_WIDTH-1:0] col_index;
    logic               group_last;
    logic               seq_last;
`ifdef PSUM_SEQ_LINEAR_EN
    logic [A_WIDTH-1:0] linear_addr;

    modport master (output out_valid, psum_index, channel_index, row_index, col_index,
                    group_last, seq_last, linear_addr, input out_ready);
    modport slave  (input out_valid, psum_index, channel_index, row_index, col_index,
                    group_last, seq_last, linear_addr, output out_ready);
`else
    modport master (output out_valid, psum_index, channel_index, row_index, col_index,
                    group_last, seq_last, input out_ready);
    modport slave  (input out_valid, psum_index, channel_index, row_index, col_index,
                    group_last, seq_last, output out_ready);
`endif
endinterface

// File: rtl/psum_group_sequencer_wrap_counter.sv
// Modulo-lim counter with clear/load; wrap flags the enabled terminal count.
module wrap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         ld,
    input  logic         en,
    input  logic [W-1:0] d,
    input  logic [W-1:0] lim,
    output logic [W-1:0] q,
    output logic         wrap
);
    logic [W-1:0] r_q;

    assign q    = r_q;
    assign wrap = en && (r_q == lim - W'(1));

    always_ff @(posedge clk) begin
        if (reset || clr)
            r_q <= '0;
        else if (ld)
            r_q <= d;
        else if (en)
            r_q <= wrap ? '0 : r_q + W'(1);
    end
endmodule

// File: rtl/psum_group_sequencer.sv
// Group-replaying psum index sequencer: loop nest group > e > t > beat (p, F, n).
// Optional PSUM_SEQ_LINEAR_EN adds an incrementally computed linear_addr.
module psum_group_sequencer
    import psum_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [F_WIDTH-1:0] cfg_F,
    input  logic [n_WIDTH-1:0] cfg_n,
    input  logic [e_WIDTH-1:0] cfg_e,
    input  logic [p_WIDTH-1:0] cfg_p,
    input  logic [t_WIDTH-1:0] cfg_t,
    input  logic [G_WIDTH-1:0] cfg_group,
    output logic               busy,
    output logic               done,
    psum_group_sequencer_if.master bus
);
    seq_state_e         r_state, w_state_nx;
    logic [F_WIDTH-1:0] r_F;
    logic [n_WIDTH-1:0] r_N;
    logic [e_WIDTH-1:0] r_E;
    logic [p_WIDTH-1:0] r_P;
    logic [t_WIDTH-1:0] r_T;
    logic [G_WIDTH-1:0] r_I;
    logic [p_WIDTH-1:0] r_base_p;
    logic [F_WIDTH-1:0] r_base_f;
    logic [n_WIDTH-1:0] r_base_n;

    beat_t              w_cur;
    logic [n_WIDTH-1:0] w_n, w_nxt_n;
    logic [F_WIDTH-1:0] w_f, w_nxt_f;
    logic [p_WIDTH-1:0] w_p, w_nxt_p;
    logic [e_WIDTH-1:0] w_e;
    logic [t_WIDTH-1:0] w_t;
    logic [G_WIDTH-1:0] w_b;
    logic w_launch, w_cfg_zero, w_valid, w_hs, w_at_end, w_bnd, w_restore, w_seq_last;
    logic w_p_wrap, w_f_wrap, w_n_wrap, w_e_wrap, w_t_wrap, w_b_wrap;

    assign w_launch   = (r_state == IDLE) && start;
    assign w_cfg_zero = (cfg_F == '0) || (cfg_n == '0) || (cfg_e == '0) ||
                        (cfg_p == '0) || (cfg_t == '0) || (cfg_group == '0);
    assign w_valid    = (r_state == STREAM);
    assign w_hs       = w_valid && bus.out_ready;
    assign w_cur      = '{n: w_n, f: w_f, p: w_p, e: w_e, t: w_t};

    // The final position of the whole (n,F,p) walk closes the short last group.
    assign w_at_end   = (w_cur.p == r_P - p_WIDTH'(1)) && (w_cur.f == r_F - F_WIDTH'(1)) &&
                        (w_cur.n == r_N - n_WIDTH'(1));
    assign w_bnd      = w_b_wrap || (w_hs && w_at_end);
    assign w_restore  = w_bnd && !w_e_wrap;
    assign w_seq_last = w_valid && w_at_end && (w_cur.t == r_T - t_WIDTH'(1)) &&
                        (w_cur.e == r_E - e_WIDTH'(1));

    // Natural successor of {n,F,p}; becomes the next group's base on e/t rollover.
    assign w_nxt_p = w_p_wrap ? '0 : w_cur.p + p_WIDTH'(1);
    assign w_nxt_f = w_f_wrap ? '0 : (w_p_wrap ? w_cur.f + F_WIDTH'(1) : w_cur.f);
    assign w_nxt_n = w_n_wrap ? '0 : (w_f_wrap ? w_cur.n + n_WIDTH'(1) : w_cur.n);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_F <= '0; r_N <= '0; r_E <= '0; r_P <= '0; r_T <= '0; r_I <= '0;
        end else if (w_launch) begin
            r_F <= cfg_F; r_N <= cfg_n; r_E <= cfg_e; r_P <= cfg_p; r_T <= cfg_t; r_I <= cfg_group;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_launch) begin
            r_base_p <= '0; r_base_f <= '0; r_base_n <= '0;
        end else if (w_e_wrap) begin
            r_base_p <= w_nxt_p; r_base_f <= w_nxt_f; r_base_n <= w_nxt_n;
        end
    end

    wrap_counter #(.W(p_WIDTH)) u_p (.clk(clk), .reset(reset), .clr(w_launch), .ld(w_restore),
        .en(w_hs), .d(r_base_p), .lim(r_P), .q(w_p), .wrap(w_p_wrap));
    wrap_counter #(.W(F_WIDTH)) u_f (.clk(clk), .reset(reset), .clr(w_launch), .ld(w_restore),
        .en(w_p_wrap), .d(r_base_f), .lim(r_F), .q(w_f), .wrap(w_f_wrap));
    wrap_counter #(.W(n_WIDTH)) u_n (.clk(clk), .reset(reset), .clr(w_launch), .ld(w_restore),
        .en(w_f_wrap), .d(r_base_n), .lim(r_N), .q(w_n), .wrap(w_n_wrap));
    wrap_counter #(.W(t_WIDTH)) u_t (.clk(clk), .reset(reset), .clr(w_launch), .ld(1'b0),
        .en(w_bnd), .d('0), .lim(r_T), .q(w_t), .wrap(w_t_wrap));
    wrap_counter #(.W(e_WIDTH)) u_e (.clk(clk), .reset(reset), .clr(w_launch), .ld(1'b0),
        .en(w_t_wrap), .d('0), .lim(r_E), .q(w_e), .wrap(w_e_wrap));
    wrap_counter #(.W(G_WIDTH)) u_b (.clk(clk), .reset(reset), .clr(w_launch || w_bnd), .ld(1'b0),
        .en(w_hs), .d('0), .lim(r_I), .q(w_b), .wrap(w_b_wrap));

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nx = w_cfg_zero ? DONE : STREAM;
            STREAM:  if (w_hs && w_seq_last) w_state_nx = DONE;
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy              = (r_state != IDLE);
        done              = (r_state == DONE);
        bus.out_valid     = w_valid;
        bus.group_last    = w_valid && ((w_b == r_I - G_WIDTH'(1)) || w_at_end);
        bus.seq_last      = w_seq_last;
        bus.psum_index    = w_cur.n;
        bus.col_index     = w_cur.f;
        bus.row_index     = w_cur.e;
        bus.channel_index = C_WIDTH'(w_cur.p) + C_WIDTH'(w_cur.t) * C_WIDTH'(r_P);
    end

`ifdef PSUM_SEQ_LINEAR_EN
    // r_lin0 tracks (n*F+f)*E of the current beat; stepping F adds E, so no multiplier.
    logic [A_WIDTH-1:0] r_lin, r_lin0, r_lin_base, w_lin0_nat, w_lin0_nx;
    logic [e_WIDTH-1:0] w_e_nx;

    assign w_e_nx     = w_e_wrap ? '0 : (w_t_wrap ? w_cur.e + e_WIDTH'(1) : w_cur.e);
    assign w_lin0_nat = r_lin0 + (w_p_wrap ? A_WIDTH'(r_E) : '0);
    assign w_lin0_nx  = w_restore ? r_lin_base : w_lin0_nat;

    always_ff @(posedge clk) begin
        if (reset || w_launch) begin
            r_lin <= '0; r_lin0 <= '0; r_lin_base <= '0;
        end else if (w_hs) begin
            r_lin0 <= w_lin0_nx;
            r_lin  <= w_lin0_nx + A_WIDTH'(w_e_nx);
            if (w_e_wrap)
                r_lin_base <= w_lin0_nat;
        end
    end

    assign bus.linear_addr = r_lin;
`endif
endmodule

// File: tb/tb_psum_group_sequencer.sv
// Directed bench for psum_group_sequencer: config table vs. loop-nest model, plus
// stall, start-spam, zero-config and mid-stream reset sequences.
module tb_psum_group_sequencer;
    import psum_seq_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [F_WIDTH-1:0] cfg_F = '0;
    logic [n_WIDTH-1:0] cfg_n = '0;
    logic [e_WIDTH-1:0] cfg_e = '0;
    logic [p_WIDTH-1:0] cfg_p = '0;
    logic [t_WIDTH-1:0] cfg_t = '0;
    logic [G_WIDTH-1:0] cfg_group = '0;
    logic               busy, done;

    psum_group_sequencer_if bus();

    psum_group_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_F(cfg_F), .cfg_n(cfg_n), .cfg_e(cfg_e), .cfg_p(cfg_p), .cfg_t(cfg_t),
        .cfg_group(cfg_group), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { int n, f, p, e, t, ch; bit gl, sl; } exp_t;
    typedef struct { int N, F, P, E, T, I; int nbeats, nglast; int stall_at, stall_len; bit spam; } case_t;

    exp_t  exp_q[$];
    case_t cases[7];
    int    ch1[16] = '{0, 1, 0, 1, 2, 3, 2, 3, 0, 1, 0, 1, 2, 3, 2, 3};
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_model(input case_t c);
        int L, idx;
        L = c.N * c.F * c.P;
        exp_q.delete();
        for (int g = 0; g * c.I < L; g++)
            for (int e = 0; e < c.E; e++)
                for (int t = 0; t < c.T; t++)
                    for (int k = 0; k < c.I && g * c.I + k < L; k++) begin
                        exp_t x;
                        idx  = g * c.I + k;
                        x.p  = idx % c.P;
                        x.f  = (idx / c.P) % c.F;
                        x.n  = idx / (c.P * c.F);
                        x.e  = e;
                        x.t  = t;
                        x.ch = x.p + x.t * c.P;
                        x.gl = (k == c.I - 1) || (idx == L - 1);
                        x.sl = (idx == L - 1) && (e == c.E - 1) && (t == c.T - 1);
                        exp_q.push_back(x);
                    end
    endtask

    task automatic set_cfg(input case_t c);
        cfg_n = n_WIDTH'(c.N); cfg_F = F_WIDTH'(c.F); cfg_p = p_WIDTH'(c.P);
        cfg_e = e_WIDTH'(c.E); cfg_t = t_WIDTH'(c.T); cfg_group = G_WIDTH'(c.I);
    endtask

    task automatic run_case(input case_t c, input int ci);
        int k, cyc, last_hs, stall_left, glc;
        bit fin;
        logic [63:0] act, expv;
        build_model(c);
        set_cfg(c);
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0; cyc = 0; last_hs = -10; stall_left = c.stall_len; glc = 0; fin = 1'b0;
        while (!fin && cyc < 1000) begin
            bus.out_ready = !(k == c.stall_at && stall_left > 0 && bus.out_valid);
            if (!bus.out_ready) stall_left--;
            start = c.spam && bus.out_valid && !bus.seq_last;
            if (bus.out_valid) begin
                if (k >= exp_q.size()) begin
                    check($sformatf("c%0d_extra_beat", ci), 64'(k), 64'(exp_q.size()));
                end else begin
                    act  = 64'({bus.psum_index, bus.channel_index, bus.row_index,
                                bus.col_index, bus.group_last, bus.seq_last});
                    expv = 64'({n_WIDTH'(exp_q[k].n), C_WIDTH'(exp_q[k].ch), e_WIDTH'(exp_q[k].e),
                                F_WIDTH'(exp_q[k].f), exp_q[k].gl, exp_q[k].sl});
                    check($sformatf("c%0d_beat%0d", ci, k), act, expv);
`ifdef PSUM_SEQ_LINEAR_EN
                    check($sformatf("c%0d_lin%0d", ci, k), 64'(bus.linear_addr),
                          64'(A_WIDTH'((exp_q[k].n * c.F + exp_q[k].f) * c.E + exp_q[k].e)));
`endif
                    if (ci == 0 && bus.out_ready && k < 16)
                        check($sformatf("c0_chan%0d", k), 64'(bus.channel_index), 64'(ch1[k]));
                    if (bus.out_ready) begin
                        if (bus.group_last) glc++;
                        last_hs = cyc;
                        k++;
                    end
                end
            end else if (!done) begin
                check($sformatf("c%0d_no_bubble", ci), 64'(bus.out_valid), 64'd1);
            end
            if (done) begin
                check($sformatf("c%0d_done_after_last", ci), 64'(cyc), 64'(last_hs + 1));
                check($sformatf("c%0d_done_cycle", ci), 64'(cyc), 64'(c.nbeats + c.stall_len));
                fin = 1'b1;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
        check($sformatf("c%0d_done_seen", ci), 64'(fin), 64'd1);
        check($sformatf("c%0d_beats", ci), 64'(k), 64'(c.nbeats));
        check($sformatf("c%0d_glast_cnt", ci), 64'(glc), 64'(c.nglast));
        check($sformatf("c%0d_post_done", ci), 64'({done, busy, bus.out_valid}), 64'd0);
    endtask

    initial begin
        //           N  F  P  E  T  I  beats glast stall_at len spam
        cases[0] = '{1, 2, 2, 2, 2, 4, 16, 4, -1, 0, 1'b0};
        cases[1] = '{1, 3, 2, 1, 1, 4,  6, 2, -1, 0, 1'b0};
        cases[2] = '{1, 2, 2, 2, 2, 4, 16, 4,  5, 3, 1'b0};
        cases[3] = '{2, 1, 3, 2, 1, 4, 12, 4, -1, 0, 1'b0};
        cases[4] = '{1, 2, 2, 2, 2, 4, 16, 4, -1, 0, 1'b1};
        cases[5] = '{1, 1, 3, 1, 2, 1,  6, 6, -1, 0, 1'b0};
        cases[6] = '{1, 1, 2, 2, 1, 15, 4, 2, -1, 0, 1'b0};

        bus.out_ready = 1'b1;
        reset = 1'b1;
        step();
        step();
        check("rst_ctrl", 64'({bus.out_valid, busy, done, bus.group_last, bus.seq_last}), 64'd0);
        check("rst_idx", 64'({bus.psum_index, bus.channel_index, bus.row_index, bus.col_index}), 64'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_case(cases[i], i);
            step();
        end

        // zero-size config: straight to DONE, no beats
        cfg_n = 1; cfg_F = 1; cfg_p = 1; cfg_t = 1; cfg_group = 1; cfg_e = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_done_cycle", 64'({done, busy, bus.out_valid}), 64'b110);
        step();
        check("zero_back_idle", 64'({done, busy, bus.out_valid}), 64'd0);
        step();
        check("zero_single_done", 64'(done), 64'd0);

        // reset on beat 5 of case 1, then a clean rerun
        set_cfg(cases[0]);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("rst_mid_beat5_chan", 64'({bus.out_valid, bus.channel_index}), 64'({1'b1, C_WIDTH'(2)}));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_after", 64'({bus.out_valid, busy, done}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_mid_no_done%0d", i), 64'({done, busy}), 64'd0);
        end
        run_case(cases[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
